// File: rtl/product_shift_register.sv
// Self-sequencing product/multiplier shift register for iterative Booth-style multiply.
// Each unstalled RUN cycle merges the adder result into the upper field, arithmetic-shifts by SHIFT and counts one step.
module product_shift_register #(
  parameter int WIDTH   = 66,
  parameter int UPPER_W = 33,
  parameter int SHIFT   = 2,
  parameter int STEPS   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [WIDTH-1:0]   load_data,
  input  logic               hold,
  input  logic               upper_we,
  input  logic [UPPER_W-1:0] upper_in,
  output logic [WIDTH-1:0]   out_data,
  output logic               busy,
  output logic               done
);

  localparam int CW = $clog2(STEPS + 1);
  localparam logic [CW-1:0] STEPS_C = CW'(STEPS);
  // Covers the upper field; stays well-defined even when UPPER_W == WIDTH.
  localparam logic [WIDTH-1:0] UPPER_MASK = ~({WIDTH{1'b1}} >> UPPER_W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] data, data_next;
  logic [WIDTH-1:0] upper_ext, compose, shifted;
  logic [CW-1:0]    count, count_next, count_inc;

  assign upper_ext = WIDTH'(upper_in) << (WIDTH - UPPER_W);
  assign compose   = upper_we ? ((data & ~UPPER_MASK) | upper_ext) : data;
  assign shifted   = $signed(compose) >>> SHIFT;
  assign count_inc = count + CW'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      data  <= '0;
      count <= '0;
    end else begin
      state <= state_next;
      data  <= data_next;
      count <= count_next;
    end
  end

  always_comb begin
    state_next = state;
    data_next  = data;
    count_next = count;
    case (state)
      IDLE: state_next = IDLE;
      RUN: begin
        if (!hold) begin
          data_next  = shifted;
          count_next = count_inc;
          state_next = (count_inc == STEPS_C) ? DONE : RUN;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    // A load restarts from any state, aborting an operation still in RUN.
    if (load) begin
      data_next  = load_data;
      count_next = '0;
      state_next = RUN;
    end
  end

  assign out_data = data;
  assign busy     = (state == RUN);
  assign done     = (state == DONE);

endmodule

// File: tb/tb_product_shift_register.sv
// Randomized scoreboard bench for product_shift_register: a driver models each operation as
// repeated floor-division by 2^SHIFT and queues the final word and done cycle for a done monitor.
module tb_product_shift_register;

  localparam int W = 66;
  localparam int U = 33;
  localparam int S = 2;
  localparam int N = 16;

  logic         clk;
  logic         reset;
  logic         load;
  logic [W-1:0] load_data;
  logic         hold;
  logic         upper_we;
  logic [U-1:0] upper_in;
  logic [W-1:0] out_data;
  logic         busy;
  logic         done;

  product_shift_register #(
    .WIDTH(W), .UPPER_W(U), .SHIFT(S), .STEPS(N)
  ) dut (
    .clk(clk), .reset(reset), .load(load), .load_data(load_data),
    .hold(hold), .upper_we(upper_we), .upper_in(upper_in),
    .out_data(out_data), .busy(busy), .done(done)
  );

  // ---------------- clock / reset ----------------
  int cyc = 0;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int           exp_cyc_q[$];
  int           n_checks = 0;
  int           n_pass = 0;
  logic [W-1:0] model_val;
  logic [W-1:0] mon_e;
  int           mon_c;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference: optional upper-field replacement, then floor division by 2^S of the signed word.
  function automatic logic [W-1:0] model_step(input logic [W-1:0] v, input bit uw,
                                             input logic [U-1:0] ui);
    logic signed [W-1:0] t, dv, q;
    t = v;
    if (uw) t[W-1 -: U] = ui;
    dv = W'(1) << S;
    q = t / dv;
    if (t < 0 && (t % dv) != 0) q = q - 1;
    return q;
  endfunction

  always @(negedge clk) begin
    if (done) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_done: done=1 at cycle %0d, expected no pending operation", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        mon_c = exp_cyc_q.pop_front();
        check("done_data", out_data, mon_e);
        check("done_cycle", W'(cyc), W'(mon_c));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) begin
      hold     = 1'($urandom_range(0, 1));
      upper_we = 1'($urandom_range(0, 1));
      upper_in = U'({$urandom(), $urandom()});
      @(posedge clk); #1;
      check("idle_busy", W'(busy), W'(0));
      check("idle_data", out_data, model_val);
    end
  endtask

  task automatic run_op(input logic [W-1:0] d, input int hold_pct, input int hold_at,
                        input int hold_len, input int upw_pct, input bit first_upw,
                        input logic [U-1:0] first_val, input int abort_step);
    int steps, holds, held_here, load_edge;
    bit h, uw;
    logic [U-1:0] ui;
    load      = 1'b1;
    load_data = d;
    load_edge = cyc + 1;
    model_val = d;
    @(posedge clk); #1;
    load = 1'b0;
    check("run_busy", W'(busy), W'(1));
    check("run_data", out_data, model_val);
    steps = 0; holds = 0; held_here = 0;
    while (steps < N) begin
      if (steps == abort_step) return;
      if (steps == hold_at && held_here < hold_len) begin
        h = 1'b1;
        held_here++;
      end else begin
        h = ($urandom_range(0, 99) < hold_pct);
      end
      uw = first_upw ? (steps == 0) : ($urandom_range(0, 99) < upw_pct);
      ui = (first_upw && steps == 0) ? first_val : U'({$urandom(), $urandom()});
      hold = h; upper_we = uw; upper_in = ui;
      if (h) holds++;
      else begin
        model_val = model_step(model_val, uw, ui);
        steps++;
      end
      if (steps == N) begin
        exp_q.push_back(model_val);
        exp_cyc_q.push_back(load_edge + N + holds);
      end
      @(posedge clk); #1;
      if (steps < N) begin
        check("run_busy", W'(busy), W'(1));
        check("run_data", out_data, model_val);
      end
    end
    check("done_busy", W'(busy), W'(0));
    hold     = 1'($urandom_range(0, 1));
    upper_we = 1'($urandom_range(0, 1));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int abort, t;
    logic [W-1:0] d;
    reset = 1'b1; load = 1'b1; load_data = W'({$urandom(), $urandom(), $urandom()});
    hold = 1'b0; upper_we = 1'b0; upper_in = '0;
    model_val = '0;

    // Reset held two cycles while load is asserted
    repeat (2) @(posedge clk);
    #1;
    check("reset_data", out_data, '0);
    check("reset_busy", W'(busy), W'(0));
    check("reset_done", W'(done), W'(0));
    reset = 1'b0; load = 1'b0;
    idle(2);

    // Default operation, sign-extending shift
    run_op(66'h2_0000_0000_0000_0000, 0, -1, 0, 0, 1'b0, '0, -1);
    check("t2_final", out_data, 66'h3_FFFF_FFFE_0000_0000);
    idle(2);

    // Same with a 3-cycle stall after step 5
    run_op(66'h2_0000_0000_0000_0000, 0, 5, 3, 0, 1'b0, '0, -1);
    check("t3_final", out_data, 66'h3_FFFF_FFFE_0000_0000);
    idle(1);

    // Upper-field write on the first step only
    run_op('0, 0, -1, 0, 0, 1'b1, 33'h4, -1);
    check("t4_final", out_data, 66'h8);
    idle(1);

    // Re-load mid-operation: the first operation never completes
    run_op(W'({$urandom(), $urandom(), $urandom()}), 0, -1, 0, 30, 1'b0, '0, 5);
    run_op(66'h1, 0, -1, 0, 0, 1'b0, '0, -1);
    check("t5_final", out_data, '0);
    idle(1);

    // Reset at step 8 abandons the operation
    run_op(W'({$urandom(), $urandom(), $urandom()}), 0, -1, 0, 30, 1'b0, '0, 8);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_val = '0;
    check("t6_reset_data", out_data, '0);
    check("t6_reset_busy", W'(busy), W'(0));
    idle(3);
    run_op(66'h2_0000_0000_0000_0000, 0, -1, 0, 0, 1'b0, '0, -1);
    check("t6_final", out_data, 66'h3_FFFF_FFFE_0000_0000);

    // Randomized operations: stalls, adder writes, aborts, back-to-back loads from DONE
    for (int i = 0; i < 24; i++) begin
      d = W'({$urandom(), $urandom(), $urandom()});
      abort = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, N - 1)) : -1;
      run_op(d, 25, -1, 0, 40, 1'b0, '0, abort);
      if (abort == -1 && $urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 3)));
    end
    idle(3);

    t = 0;
    while (exp_q.size() != 0 && t < 50) begin
      @(posedge clk);
      t++;
    end
    #1;
    check("queue_drain", W'(exp_q.size()), '0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
